ysyx_22041071_wb_stage: RTL

Write-back stage of the 5-stage ysyx_22041071 RV64 pipeline. Accepts retiring instructions from MEM over a valid/ready handshake, waits for load data from the data-memory response port, aligns and sign/zero-extends it, and drives the register-file write port (`reg_w_en5`, `rdest4`, `WB_data2`) consumed by ID2 for both register write and forwarding. Also produces per-instruction commit information and a retired-instruction counter for difftest.

---
 rtl/ysyx_22041071_wb_stage.sv | 136 +++++++++++++
 1 files changed

// File: rtl/ysyx_22041071_wb_stage.sv
// Write-back stage: retires MEM entries, aligns and extends load data, and drives the
// register-file write port plus difftest commit information.
module ysyx_22041071_wb_stage #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        valid5,
   output logic        ready5,
   input  logic [63:0] PC5,
   input  logic [31:0] Ins5,
   input  logic        WB_sel5,
   input  logic        reg_w_en5_in,
   input  logic [4:0]  rdest5,
   input  logic [63:0] result5,
   input  logic        mem_rvalid,
   input  logic [63:0] mem_rdata,
   output logic        reg_w_en5,
   output logic [4:0]  rdest4,
   output logic [63:0] WB_data2,
   output logic        commit_valid,
   output logic [63:0] commit_pc,
   output logic [31:0] commit_ins,
   output logic [63:0] instret,
   output logic        load_err
);

   localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

   typedef enum logic {IDLE, WAIT_LOAD} state_t;

   state_t         state;
   logic [CW-1:0]  wait_cnt;
   logic [63:0]    pc_q;
   logic [31:0]    ins_q;
   logic [4:0]     rdest_q;
   logic           we_q;
   logic [2:0]     funct3_q;
   logic [2:0]     off_q;
   logic [63:0]    shifted;
   logic [63:0]    load_data;

   assign ready5 = (state == IDLE);

   // Bytes shifted in from above the doubleword are zero, so crossing accesses are truncated.
   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      shifted   = mem_rdata >> {off_q, 3'b000};
      load_data = shifted;
      case (funct3_q)
         3'd0:    load_data = {{56{shifted[7]}},  shifted[7:0]};
         3'd1:    load_data = {{48{shifted[15]}}, shifted[15:0]};
         3'd2:    load_data = {{32{shifted[31]}}, shifted[31:0]};
         3'd4:    load_data = {56'd0, shifted[7:0]};
         3'd5:    load_data = {48'd0, shifted[15:0]};
         3'd6:    load_data = {32'd0, shifted[31:0]};
         default: load_data = shifted;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         wait_cnt     <= '0;
         pc_q         <= '0;
         ins_q        <= '0;
         rdest_q      <= '0;
         we_q         <= 1'b0;
         funct3_q     <= '0;
         off_q        <= '0;
         reg_w_en5    <= 1'b0;
         rdest4       <= '0;
         WB_data2     <= '0;
         commit_valid <= 1'b0;
         commit_pc    <= '0;
         commit_ins   <= '0;
         instret      <= '0;
         load_err     <= 1'b0;
      end else begin
         reg_w_en5    <= 1'b0;
         commit_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (valid5) begin
                  pc_q     <= PC5;
                  ins_q    <= Ins5;
                  rdest_q  <= rdest5;
                  we_q     <= reg_w_en5_in;
                  funct3_q <= Ins5[14:12];
                  off_q    <= result5[2:0];
                  if (Ins5 != 32'd0) begin
                     if (!WB_sel5) begin
                        WB_data2     <= result5;
                        rdest4       <= rdest5;
                        reg_w_en5    <= reg_w_en5_in && (rdest5 != 5'd0);
                        commit_valid <= 1'b1;
                        commit_pc    <= PC5;
                        commit_ins   <= Ins5;
                        instret      <= instret + 64'd1;
                     end else begin
                        state    <= WAIT_LOAD;
                        wait_cnt <= '0;
                     end
                  end
               end
            end
            WAIT_LOAD: begin
               if (mem_rvalid) begin
                  WB_data2     <= load_data;
                  rdest4       <= rdest_q;
                  reg_w_en5    <= we_q && (rdest_q != 5'd0);
                  commit_valid <= 1'b1;
                  commit_pc    <= pc_q;
                  commit_ins   <= ins_q;
                  instret      <= instret + 64'd1;
                  state        <= IDLE;
               end else if (wait_cnt == CW'(TIMEOUT)) begin
                  // Abandoned load still retires so difftest stays in step, but never writes.
                  load_err     <= 1'b1;
                  rdest4       <= rdest_q;
                  commit_valid <= 1'b1;
                  commit_pc    <= pc_q;
                  commit_ins   <= ins_q;
                  instret      <= instret + 64'd1;
                  state        <= IDLE;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
